// File: rtl/fde_controller.sv
// fde_controller: multi-cycle fetch/decode/execute control FSM.
// Sequences PC, IR, register file, ALU and memory strobes from the IR opcode,
// the ALU zero flag and the memory ready handshake.
// Optional feature macro: FDE_PERF_COUNT_EN enables the cycle and retired
// instruction counters. When it is undefined, both counters read as zero and
// no counter flops are built.
module fde_controller #(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic [OP_W-1:0]  op_code,
    input  logic [5:0]       funct,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic [1:0]       pc_src,
    output logic             ir_load,
    output logic             mem_re,
    output logic             mem_we,
    output logic [3:0]       alu_op,
    output logic             rf_we,
    output logic             reg_dst,
    output logic             mem_to_reg,
    output logic             halted,
    output logic             illegal_op,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_DECODE    = 3'd1,
        S_EXECUTE   = 3'd2,
        S_MEMORY    = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd5
    } state_t;

    localparam logic [OP_W-1:0] OP_R    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_J    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDI = OP_W'(8);
    localparam logic [OP_W-1:0] OP_LW   = OP_W'(35);
    localparam logic [OP_W-1:0] OP_SW   = OP_W'(43);
    localparam logic [OP_W-1:0] OP_HALT = OP_W'(63);

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_SLT = 4'd4;

    localparam logic [1:0] PC_SEQ    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;
    logic   set_illegal;
    logic   count_instr;

    // R-type ALU operation from the MIPS funct field; unrecognised functs add.
    function automatic logic [3:0] alu_from_funct(input logic [5:0] f);
        case (f)
            6'h20:   return ALU_ADD;
            6'h22:   return ALU_SUB;
            6'h24:   return ALU_AND;
            6'h25:   return ALU_OR;
            6'h2A:   return ALU_SLT;
            default: return ALU_ADD;
        endcase
    endfunction

    // State register and sticky illegal-opcode flag.
    always_ff @(posedge CLK) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values, independent of statement order.
        if (reset) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
        end
    end

    // Next-state and strobe decode; while reset is asserted every strobe idles
    // so a simultaneous mem_ready cannot load the IR or PC.
    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // case statement can leave a signal unassigned and infer a latch.
        state_d     = state_q;
        pc_en       = 1'b0;
        pc_src      = PC_SEQ;
        ir_load     = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        alu_op      = ALU_ADD;
        rf_we       = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        set_illegal = 1'b0;
        count_instr = 1'b0;

        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_re = 1'b1;
                    if (mem_ready) begin
                        ir_load = 1'b1;
                        pc_en   = 1'b1;
                        state_d = S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (op_code)
                        OP_HALT: begin
                            count_instr = 1'b1;
                            state_d     = S_HALT;
                        end
                        OP_J: begin
                            pc_en       = 1'b1;
                            pc_src      = PC_JUMP;
                            count_instr = 1'b1;
                            state_d     = S_FETCH;
                        end
                        OP_R, OP_BEQ, OP_ADDI, OP_LW, OP_SW: begin
                            state_d = S_EXECUTE;
                        end
                        default: begin
                            set_illegal = 1'b1;
                            count_instr = 1'b1;
                            state_d     = S_FETCH;
                        end
                    endcase
                end
                S_EXECUTE: begin
                    case (op_code)
                        OP_R: begin
                            alu_op  = alu_from_funct(funct);
                            state_d = S_WRITEBACK;
                        end
                        OP_ADDI: begin
                            state_d = S_WRITEBACK;
                        end
                        OP_LW, OP_SW: begin
                            state_d = S_MEMORY;
                        end
                        OP_BEQ: begin
                            alu_op      = ALU_SUB;
                            pc_en       = zero;
                            pc_src      = PC_BRANCH;
                            count_instr = 1'b1;
                            state_d     = S_FETCH;
                        end
                        default: begin
                            state_d = S_FETCH;
                        end
                    endcase
                end
                S_MEMORY: begin
                    if (op_code == OP_LW) begin
                        mem_re = 1'b1;
                        if (mem_ready) begin
                            state_d = S_WRITEBACK;
                        end
                    end else if (op_code == OP_SW) begin
                        mem_we = 1'b1;
                        if (mem_ready) begin
                            count_instr = 1'b1;
                            state_d     = S_FETCH;
                        end
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_WRITEBACK: begin
                    rf_we       = 1'b1;
                    reg_dst     = (op_code == OP_R);
                    mem_to_reg  = (op_code == OP_LW);
                    count_instr = 1'b1;
                    state_d     = S_FETCH;
                end
                S_HALT: begin
                    state_d = S_HALT;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    assign state      = state_q;
    assign halted     = (state_q == S_HALT);
    assign illegal_op = illegal_q;

`ifdef FDE_PERF_COUNT_EN
    logic [CNT_W-1:0] cycle_q;
    logic [CNT_W-1:0] instr_q;

    // Performance counters: cycles outside HALT, and retirements plus HALT entry.
    always_ff @(posedge CLK) begin
        if (reset) begin
            cycle_q <= '0;
            instr_q <= '0;
        end else begin
            if (state_q != S_HALT) begin
                cycle_q <= cycle_q + 1'b1;
            end
            if (count_instr) begin
                instr_q <= instr_q + 1'b1;
            end
        end
    end

    assign cycle_count = cycle_q;
    assign instr_count = instr_q;
`else
    logic unused_count_instr;

    assign unused_count_instr = count_instr;
    assign cycle_count        = '0;
    assign instr_count        = '0;
`endif

endmodule

// File: tb/tb_fde_controller.sv
// tb_fde_controller: randomized self-checking bench for fde_controller.
// Each instruction is expanded into its expected list of cycles from the
// instruction-class rules; every cycle's state, strobes, sticky flag and
// counters are compared against that list.
module tb_fde_controller;

    localparam int OP_W  = 6;
    localparam int CNT_W = 32;

`ifdef FDE_PERF_COUNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [5:0] OP_R    = 6'd0;
    localparam logic [5:0] OP_J    = 6'd2;
    localparam logic [5:0] OP_BEQ  = 6'd4;
    localparam logic [5:0] OP_ADDI = 6'd8;
    localparam logic [5:0] OP_LW   = 6'd35;
    localparam logic [5:0] OP_SW   = 6'd43;
    localparam logic [5:0] OP_HALT = 6'd63;

    logic             CLK = 1'b0;
    logic             reset = 1'b1;
    logic [OP_W-1:0]  op_code = '0;
    logic [5:0]       funct = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b1;
    logic             pc_en;
    logic [1:0]       pc_src;
    logic             ir_load;
    logic             mem_re;
    logic             mem_we;
    logic [3:0]       alu_op;
    logic             rf_we;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             halted;
    logic             illegal_op;
    logic [2:0]       state;
    logic [CNT_W-1:0] cycle_count;
    logic [CNT_W-1:0] instr_count;

    int errors = 0;
    int checks = 0;

    // Reference model state.
    int exp_cycles = 0;
    int exp_instr  = 0;
    bit exp_illegal = 1'b0;

    typedef struct {
        int st;
        bit rdy;
    } step_t;

    fde_controller #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .op_code     (op_code),
        .funct       (funct),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .pc_en       (pc_en),
        .pc_src      (pc_src),
        .ir_load     (ir_load),
        .mem_re      (mem_re),
        .mem_we      (mem_we),
        .alu_op      (alu_op),
        .rf_we       (rf_we),
        .reg_dst     (reg_dst),
        .mem_to_reg  (mem_to_reg),
        .halted      (halted),
        .illegal_op  (illegal_op),
        .state       (state),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic bit is_known(input logic [5:0] op);
        return op == OP_R || op == OP_J || op == OP_BEQ || op == OP_ADDI ||
               op == OP_LW || op == OP_SW || op == OP_HALT;
    endfunction

    function automatic logic [3:0] alu_of_funct(input logic [5:0] fn);
        case (fn)
            6'h22:   return 4'd1;
            6'h24:   return 4'd2;
            6'h25:   return 4'd3;
            6'h2A:   return 4'd4;
            default: return 4'd0;
        endcase
    endfunction

    // Expected {pc_en, pc_src, ir_load, mem_re, mem_we, alu_op, rf_we, reg_dst, mem_to_reg, halted}.
    function automatic logic [14:0] exp_strobes(input int st, input bit rdy, input logic [5:0] op,
                                                input logic [5:0] fn, input bit z);
        logic       e_pc;
        logic [1:0] e_src;
        logic       e_ir, e_re, e_we, e_rf, e_rd, e_m2r, e_h;
        logic [3:0] e_alu;
        e_pc = 0; e_src = 0; e_ir = 0; e_re = 0; e_we = 0;
        e_rf = 0; e_rd = 0; e_m2r = 0; e_h = 0; e_alu = 0;
        case (st)
            0: begin
                e_re = 1;
                if (rdy) begin
                    e_ir = 1;
                    e_pc = 1;
                end
            end
            1: if (op == OP_J) begin
                e_pc  = 1;
                e_src = 2;
            end
            2: begin
                if (op == OP_R) e_alu = alu_of_funct(fn);
                if (op == OP_BEQ) begin
                    e_alu = 1;
                    e_pc  = z;
                    e_src = 1;
                end
            end
            3: begin
                if (op == OP_LW) e_re = 1;
                else e_we = 1;
            end
            4: begin
                e_rf  = 1;
                e_rd  = (op == OP_R);
                e_m2r = (op == OP_LW);
            end
            5: e_h = 1;
            default: ;
        endcase
        return {e_pc, e_src, e_ir, e_re, e_we, e_alu, e_rf, e_rd, e_m2r, e_h};
    endfunction

    task automatic compare_all(input string ctx, input int st, input logic [14:0] strobes);
        check({ctx, " state"}, 64'(state), 64'(st));
        check({ctx, " strobes"},
              64'({pc_en, pc_src, ir_load, mem_re, mem_we, alu_op, rf_we, reg_dst, mem_to_reg, halted}),
              64'(strobes));
        check({ctx, " illegal_op"}, 64'(illegal_op), 64'(exp_illegal));
        check({ctx, " cycle_count"}, 64'(cycle_count), PERF ? 64'(CNT_W'(exp_cycles)) : 64'd0);
        check({ctx, " instr_count"}, 64'(instr_count), PERF ? 64'(CNT_W'(exp_instr)) : 64'd0);
    endtask

    // Hold reset for n edges with mem_ready high, checking the idle state after each edge.
    task automatic do_reset(input int n);
        @(negedge CLK);
        reset     = 1'b1;
        mem_ready = 1'b1;
        op_code   = 6'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK);
            exp_cycles  = 0;
            exp_instr   = 0;
            exp_illegal = 1'b0;
            @(negedge CLK);
            #1;
            compare_all($sformatf("reset[%0d]", i), 0, 15'd0);
        end
    endtask

    // One expected cycle: zsel < 0 randomizes zero, otherwise forces it.
    task automatic step(input step_t s, input logic [5:0] op, input logic [5:0] fn,
                        input int zsel, input bit last);
        @(negedge CLK);
        reset     = 1'b0;
        mem_ready = (s.st == 0 || s.st == 3) ? s.rdy : 1'($urandom);
        zero      = (zsel < 0) ? 1'($urandom) : 1'(zsel);
        op_code   = (s.st == 0) ? 6'($urandom) : op;
        funct     = (s.st == 0) ? 6'($urandom) : fn;
        #1;
        compare_all($sformatf("op%0d st%0d", op, s.st), s.st,
                    exp_strobes(s.st, s.rdy, op, fn, zero));
        @(posedge CLK);
        exp_cycles++;
        if (s.st == 1 && !is_known(op)) exp_illegal = 1'b1;
        if (last) exp_instr++;
    endtask

    // Expand an instruction into its expected cycles; steps [0, stop) are run.
    task automatic run_part(input logic [5:0] op, input logic [5:0] fn, input int fst,
                            input int mst, input int zsel, input int stop);
        step_t q[$];
        bit    mem_op;
        mem_op = (op == OP_LW || op == OP_SW);
        for (int i = 0; i < fst; i++) q.push_back('{0, 1'b0});
        q.push_back('{0, 1'b1});
        q.push_back('{1, 1'b0});
        if (op == OP_R || op == OP_BEQ || op == OP_ADDI || mem_op) q.push_back('{2, 1'b0});
        if (mem_op) begin
            for (int i = 0; i < mst; i++) q.push_back('{3, 1'b0});
            q.push_back('{3, 1'b1});
        end
        if (op == OP_R || op == OP_ADDI || op == OP_LW) q.push_back('{4, 1'b0});
        for (int i = 0; i < q.size() && i < stop; i++) begin
            step(q[i], op, fn, zsel, i == q.size() - 1);
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fst,
                             input int mst, input int zsel);
        run_part(op, fn, fst, mst, zsel, 1000);
    endtask

    // Dwell in HALT: inputs wiggle, nothing moves.
    task automatic halt_dwell(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            mem_ready = 1'($urandom);
            zero      = 1'($urandom);
            op_code   = 6'($urandom);
            funct     = 6'($urandom);
            #1;
            compare_all($sformatf("halt[%0d]", i), 5, exp_strobes(5, 1'b0, 6'd0, 6'd0, 1'b0));
            @(posedge CLK);
        end
    endtask

    task automatic random_instr();
        logic [5:0] ops [7];
        logic [5:0] fns [6];
        logic [5:0] op;
        ops = '{OP_R, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW, 6'd17};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h3F};
        op  = ops[$urandom_range(0, 6)];
        if (op == 6'd17) begin
            do op = 6'($urandom); while (is_known(op));
        end
        run_instr(op, fns[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2), -1);
    endtask

    initial begin
        // Reset held two cycles with mem_ready high.
        do_reset(2);

        // R-type ADD, LW with stalls, BEQ taken and not taken, plain ADDI/SW/J.
        run_instr(OP_R, 6'h20, 0, 0, -1);
        run_instr(OP_LW, 6'h00, 2, 2, -1);
        run_instr(OP_BEQ, 6'h00, 0, 0, 1);
        run_instr(OP_BEQ, 6'h00, 0, 0, 0);
        run_instr(OP_ADDI, 6'h11, 0, 0, -1);
        run_instr(OP_SW, 6'h00, 0, 0, -1);
        run_instr(OP_J, 6'h00, 0, 0, -1);

        // SW stalled in MEMORY, then reset: stops the write, does not retire.
        run_part(OP_SW, 6'h00, 0, 3, -1, 5);
        do_reset(1);

        // Illegal opcode sets the sticky flag, which survives later instructions.
        run_instr(6'd17, 6'h00, 1, 0, -1);
        for (int i = 0; i < 20; i++) random_instr();

        // HALT freezes everything until reset.
        run_instr(OP_HALT, 6'h00, 1, 0, -1);
        halt_dwell(5);
        do_reset(1);

        // Longer random run, ending in HALT.
        for (int i = 0; i < 60; i++) random_instr();
        run_instr(OP_HALT, 6'h00, 0, 0, -1);
        halt_dwell(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
